pipe_chain: RTL and testbench
=============================

Name: pipe_chain

Overview:
- Parametrised elastic pipeline-register chain: the next-generation replacement for the fixed, always-advancing IF_ID/ID_EX/EX_MEM/MEM_WB registers.
- Carries a WIDTH-bit payload through DEPTH stages with per-stage valid bits and valid/ready backpressure.
- Bubbles collapse, so empty stages fill even while the output is stalled.
- Supports a partial flush that kills the youngest stages on branch/jump redirect. Instantiated once per core between fetch and writeback.

Parameters:
WIDTH, 32, payload bits per stage (packed instr/PC/control bundle)
DEPTH, 5, number of register stages; legal 2..16
IDXW, $clog2(DEPTH), width of flush_upto
OCCW, $clog2(DEPTH+1), width of occupancy

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream payload valid
in_ready  output  1  stage 0 can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage DEPTH-1 holds valid payload
out_ready  input  1  downstream accepts
out_data  output  WIDTH  stage DEPTH-1 payload
flush  input  1  kill request, acts at this clock edge
flush_upto  input  IDXW  kill stages 0..flush_upto (stage 0 = youngest)
stage_valid  output  DEPTH  per-stage valid bits, registered
occupancy  output  OCCW  number of valid stages, registered

Behaviour:
- Reset:
  - All valid bits 0; occupancy 0; out_valid 0.
  - Payload registers are cleared to 0.
  - Reset overrides flush and any handshake in the same cycle.
- Effective valid per stage k: ev[k] = valid[k] & ~(flush & k <= fu), where fu = min(flush_upto, DEPTH-1).
- Effective input valid: in_ev = in_valid & ~flush.
- Ready chain (combinational, from the output backwards):
  - rdy[DEPTH-1] = ~ev[DEPTH-1] | out_ready.
  - rdy[k] = ~ev[k] | rdy[k+1].
  - in_ready = rdy[0].
- Stage advance:
  - Stage k+1 loads stage k when ev[k] & rdy[k+1]; stage 0 loads in_data when in_ev & rdy[0].
  - A stage that sends and does not receive goes invalid.
  - A stage that neither sends nor receives holds its payload and valid bit.
  - Killed stages become invalid unless refilled this edge.
- Outputs are combinational from registers: out_valid = valid[DEPTH-1]; out_data = payload[DEPTH-1].
- Flush cycle:
  - Current-cycle out_valid/out_data are unaffected. An output handshake completing on a flush cycle is a real transfer, even when fu = DEPTH-1.
  - Upstream sees in_ready per the masked chain. A handshake completing on a flush cycle is consumed and discarded.
  - Stages above fu advance normally. A flushed entry moving upward is dropped and never appears.
- Latency: an accepted payload reaches out_valid DEPTH cycles after acceptance with no stalls. Throughput is 1/cycle sustained.
- Full (all valid, out_ready=0): in_ready=0, all hold. out_ready rising frees every stage in the same cycle (full-throughput restart, no one-bubble-per-stage penalty).
- Empty: in_ready=1; out_valid=0 regardless of out_ready.
- flush_upto >= DEPTH clamps to DEPTH-1, which flushes all stages.
- Occupancy is the registered popcount of the next-state valid bits, so occupancy == popcount(stage_valid) always.
- The out_ready -> in_ready path is combinational through DEPTH gates by design. There is no combinational path from in_valid to in_ready.

Optional Feature:
- Macro PIPE_CHAIN_STATS_EN.
- Defined:
  - Adds output stall_cnt (32, cycles with out_valid & ~out_ready) and output kill_cnt (32, number of valid entries killed by flush, plus 1 for each discarded input handshake).
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: neither port nor counter logic exists. Core datapath behaviour is identical in both builds.

Test Plan:
- Streaming: DEPTH=5, in_valid=1 with data 1,2,3..., out_ready=1 -> first out_valid on cycle 5 with out_data=1; then one value per cycle in order; occupancy holds at 5.
- Backpressure with bubble collapse: load 1 and 3 with an idle cycle between, then out_ready=0 -> entries compact to stages 4,3; in_ready stays 1 until 5 valid. out_ready=1 for 1 cycle -> exactly one transfer; occupancy decrements by 1 that cycle.
- Partial flush: full with 10..14 (14 at output), out_ready=0, flush=1, flush_upto=2 -> next cycle stage_valid=5'b11000, occupancy=2; later outputs are 14 then 13 only.
- Flush with simultaneous output and input: full, out_ready=1, in_valid=1 in_data=99, flush=1, flush_upto=7 -> this cycle's out_data is transferred; next cycle occupancy=0, 99 is never output; kill_cnt=5 with the macro (4 killed entries + discarded input).
- Reset mid-stream: rst=1 while occupancy=3 and in_valid=1 -> next cycle stage_valid=0, occupancy=0, out_valid=0; the input is not captured.
- Stats: out_valid held with out_ready=0 for 7 cycles (build with PIPE_CHAIN_STATS_EN) -> stall_cnt=7; rst -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage payload chain with per-stage valid/ready handshakes, bubble collapse and youngest-stage flush.
// Optional PIPE_CHAIN_STATS_EN adds saturating stall_cnt and kill_cnt outputs.
`timescale 1ns/1ps
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic [IDXW-1:0]  flush_upto,
  output logic [DEPTH-1:0] stage_valid,
  output logic [OCCW-1:0]  occupancy
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      kill_cnt
`endif
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCCW-1:0]  occupancy_q, occupancy_d;

  logic [IDXW-1:0]  fu;
  logic [DEPTH-1:0] kill_m, ev, rdy, recv, send;
  logic             in_ev;
  logic             chain;

  always_comb begin
    fu     = (flush_upto > LAST_IDX) ? LAST_IDX : flush_upto;
    kill_m = '0;
    ev     = '0;
    rdy    = '0;
    recv   = '0;
    send   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      kill_m[k] = flush && (IDXW'(k) <= fu);
      ev[k]     = valid_q[k] & ~kill_m[k];
    end
    in_ev = in_valid & ~flush;

    // Ready ripples back from the output so a full chain restarts in one cycle.
    chain          = ~ev[DEPTH-1] | out_ready;
    rdy[DEPTH-1]   = chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      chain  = ~ev[k] | chain;
      rdy[k] = chain;
    end

    recv[0] = in_ev & rdy[0];
    for (int k = 1; k < DEPTH; k++) begin
      recv[k]   = ev[k-1] & rdy[k];
      send[k-1] = recv[k];
    end
    // The output register transfers on the raw valid, even if it is being flushed.
    send[DEPTH-1] = valid_q[DEPTH-1] & out_ready;

    occupancy_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k]  = recv[k] | (ev[k] & ~send[k]);
      occupancy_d = occupancy_d + OCCW'(valid_d[k]);
    end

    data_d[0] = recv[0] ? in_data : data_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      data_d[k] = recv[k] ? data_q[k-1] : data_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign occupancy   = occupancy_q;

`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;
  logic [7:0]  kills;
  logic [32:0] kill_sum;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q[DEPTH-1] && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // A flushed output entry that still hands off is a transfer, not a kill.
    kills = 8'(in_valid & flush & rdy[0]);
    for (int k = 0; k < DEPTH; k++) begin
      kills = kills + 8'(valid_q[k] & kill_m[k]);
    end
    kills = kills - 8'(send[DEPTH-1] & kill_m[DEPTH-1]);

    kill_sum   = {1'b0, kill_cnt_q} + 33'(kills);
    kill_cnt_d = kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: expected outputs go into a queue, a negedge monitor pops them on every output handshake.
`timescale 1ns/1ps
module tb_pipe_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int IDXW  = 3;
  localparam int OCCW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [IDXW-1:0]  flush_upto;
  logic [DEPTH-1:0] stage_valid;
  logic [OCCW-1:0]  occupancy;
`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      kill_cnt;
  logic [31:0]      kill_before;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .flush_upto  (flush_upto),
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
`ifdef PIPE_CHAIN_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .kill_cnt    (kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %0h expected no transfer", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; flush_upto = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("empty_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_CHAIN_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_kill_cnt", kill_cnt, 32'd0);
`endif

    // Streaming: 1..8 with out_ready high, first output after DEPTH edges.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      step();
      if (i == 4) chk("lat_not_yet", 32'(out_valid), 32'd0);
      if (i == 5) begin
        chk("lat_first_vld", 32'(out_valid), 32'd1);
        chk("lat_first_dat", out_data, 32'd1);
      end
    end
    chk("stream_occ", 32'(occupancy), 32'd5);
    in_valid = 1'b0;
    repeat (5) step();
    chk("stream_drain_occ", 32'(occupancy), 32'd0);

    // Bubble collapse under backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd1; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 32'd3; step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bubble_stage_valid", 32'(stage_valid), 32'h18);
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_out_data", out_data, 32'd1);
    in_valid = 1'b1;
    for (int d = 5; d <= 7; d++) begin
      in_data = 32'(d);
      #1;
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    chk("full_occ", 32'(occupancy), 32'd5);
    chk("full_stage_valid", 32'(stage_valid), 32'h1F);
    in_valid = 1'b1; in_data = 32'd8;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    exp_q.push_back(32'd1);
    out_ready = 1'b1;
    #1;
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    chk("one_xfer_occ", 32'(occupancy), 32'd4);
    chk("one_xfer_stage_valid", 32'(stage_valid), 32'h1E);
    chk("one_xfer_out_data", out_data, 32'd3);
    exp_q.push_back(32'd3); exp_q.push_back(32'd5);
    exp_q.push_back(32'd6); exp_q.push_back(32'd7);
    out_ready = 1'b1;
    repeat (5) step();
    chk("bubble_drain_occ", 32'(occupancy), 32'd0);

    // Partial flush of the three youngest stages.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int d = 14; d >= 10; d--) begin
      in_data = 32'(d);
      step();
    end
    in_valid = 1'b0;
    chk("pflush_full_occ", 32'(occupancy), 32'd5);
    flush = 1'b1; flush_upto = 3'd2;
    step();
    flush = 1'b0; flush_upto = '0;
    chk("pflush_stage_valid", 32'(stage_valid), 32'h18);
    chk("pflush_occ", 32'(occupancy), 32'd2);
    chk("pflush_out_data", out_data, 32'd14);
    exp_q.push_back(32'd14); exp_q.push_back(32'd13);
    out_ready = 1'b1;
    repeat (3) step();
    chk("pflush_drain_occ", 32'(occupancy), 32'd0);

    // Full flush (clamped index) with simultaneous output and input handshakes.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int d = 20; d <= 24; d++) begin
      in_data = 32'(d);
      step();
    end
    in_valid = 1'b0;
    chk("fflush_full_occ", 32'(occupancy), 32'd5);
`ifdef PIPE_CHAIN_STATS_EN
    kill_before = kill_cnt;
`endif
    exp_q.push_back(32'd20);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd99;
    flush = 1'b1; flush_upto = 3'd7;
    #1;
    chk("fflush_in_ready", 32'(in_ready), 32'd1);
    chk("fflush_out_data", out_data, 32'd20);
    step();
    in_valid = 1'b0; flush = 1'b0; flush_upto = '0;
    chk("fflush_occ", 32'(occupancy), 32'd0);
    chk("fflush_stage_valid", 32'(stage_valid), 32'h0);
`ifdef PIPE_CHAIN_STATS_EN
    chk("fflush_kill_delta", kill_cnt - kill_before, 32'd5);
`endif
    repeat (6) step();
    chk("fflush_no_99", 32'(out_valid), 32'd0);

    // Reset mid-stream overrides a pending input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int d = 30; d <= 32; d++) begin
      in_data = 32'(d);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd77;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    // Output held under backpressure for seven edges.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd40;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("stall_out_valid", 32'(out_valid), 32'd1);
`ifdef PIPE_CHAIN_STATS_EN
    chk("stall_start", stall_cnt, 32'd0);
`endif
    repeat (7) step();
`ifdef PIPE_CHAIN_STATS_EN
    chk("stall_cnt7", stall_cnt, 32'd7);
`endif
    chk("stall_hold_data", out_data, 32'd40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stall_rst_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_CHAIN_STATS_EN
    chk("stall_rst_cnt", stall_cnt, 32'd0);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
